// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle sequencer.
//   state_t       : controller state encoding
//   op_class_t    : instruction class produced by decode_class()
//   OP_*          : opcodes with dedicated behaviour
//   IMM_*         : imm_src encodings driven to the immediate generator
package seq_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMem,
        StWriteback,
        StHalt,
        StError
    } state_t;

    typedef enum logic [2:0] {
        ClsRtype,
        ClsImm,
        ClsLoad,
        ClsStore,
        ClsBeq,
        ClsJmp,
        ClsHalt,
        ClsIllegal
    } op_class_t;

    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] IMM_00 = 2'b00;
    localparam logic [1:0] IMM_01 = 2'b01;
    localparam logic [1:0] IMM_10 = 2'b10;
    localparam logic [1:0] IMM_11 = 2'b11;

    function automatic op_class_t decode_class(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0011, 4'b0100, 4'b0101: cls = ClsRtype;
            4'b0110, 4'b1001, 4'b1010: cls = ClsImm;
            OP_LOAD:                   cls = ClsLoad;
            OP_STORE:                  cls = ClsStore;
            OP_BEQ:                    cls = ClsBeq;
            OP_JMP:                    cls = ClsJmp;
            OP_HALT:                   cls = ClsHalt;
            default:                   cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    // Immediate format for the classes that use the immediate path.
    function automatic logic [1:0] imm_format(input logic [3:0] op);
        logic [1:0] fmt;
        case (op)
            4'b0110:                    fmt = IMM_10;
            4'b1010:                    fmt = IMM_00;
            4'b1001, OP_LOAD, OP_STORE: fmt = IMM_01;
            default:                    fmt = IMM_11;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter shared by the instruction fetch and data access phases.
//   clk, rst : clock and synchronous active-high reset
//   req      : a memory request is outstanding this cycle
//   ready    : the addressed memory completes this cycle
//   expired  : last permitted wait cycle reached with ready still low
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    output logic expired
);

    logic [7:0] count;

    // Any cycle that is not a wait cycle zeroes the count, so every new
    // request (FETCH or MEM entry) starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (req && !ready) begin
            count <= count + 8'd1;
        end else begin
            count <= '0;
        end
    end

    assign expired = req && !ready && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle controller for the 4-bit-opcode CPU datapath.
//   clk, rst              : clock and synchronous active-high reset
//   opcode, alu_zero      : IR[15:12] and ALU zero flag from the datapath
//   imem_ready/dmem_ready : memory completion handshakes
//   imem_req/dmem_req/mem_we : memory requests (mem_we qualifies dmem_req)
//   ir_we/pc_we/reg_we    : datapath write strobes
//   pc_src/alu_src/result_src/imm_src : datapath mux selects
//   halted/bus_err/illegal : sticky status flags
//   retired               : completed-instruction counter (wraps)
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic             alu_src,
    output logic             result_src,
    output logic [1:0]       imm_src,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    logic [3:0] op_q;
    op_class_t  dec_cls;
    op_class_t  cls;
    logic       wait_req;
    logic       wait_ready;
    logic       expired;

    assign dec_cls = decode_class(opcode);
    assign cls     = decode_class(op_q);

    assign wait_req   = (state == StFetch) || (state == StMem);
    assign wait_ready = (state == StFetch) ? imem_ready : dmem_ready;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .req    (wait_req),
        .ready  (wait_ready),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StFetch;
            op_q    <= '0;
            retired <= '0;
            halted  <= 1'b0;
            bus_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                StFetch: begin
                    // ready wins over a simultaneous timeout
                    if (imem_ready) begin
                        state <= StDecode;
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        state   <= StError;
                    end
                end
                StDecode: begin
                    op_q <= opcode;
                    case (dec_cls)
                        ClsHalt: begin
                            halted  <= 1'b1;
                            retired <= retired + CNT_W'(1);
                            state   <= StHalt;
                        end
                        ClsIllegal: begin
                            illegal <= 1'b1;
                            halted  <= 1'b1;
                            state   <= StHalt;
                        end
                        default: state <= StExecute;
                    endcase
                end
                StExecute: begin
                    case (cls)
                        ClsLoad, ClsStore: state <= StMem;
                        ClsBeq, ClsJmp: begin
                            retired <= retired + CNT_W'(1);
                            state   <= StFetch;
                        end
                        default: state <= StWriteback;
                    endcase
                end
                StMem: begin
                    if (dmem_ready) begin
                        if (cls == ClsStore) begin
                            retired <= retired + CNT_W'(1);
                            state   <= StFetch;
                        end else begin
                            state <= StWriteback;
                        end
                    end else if (expired) begin
                        bus_err <= 1'b1;
                        state   <= StError;
                    end
                end
                StWriteback: begin
                    retired <= retired + CNT_W'(1);
                    state   <= StFetch;
                end
                StHalt:  state <= StHalt;
                StError: state <= StError;
                default: state <= StError;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        alu_src    = 1'b0;
        result_src = 1'b0;
        imm_src    = IMM_11;
        if (!rst) begin
            case (state)
                StFetch: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                    pc_we    = imem_ready;
                end
                StExecute: begin
                    case (cls)
                        ClsImm, ClsLoad, ClsStore: begin
                            alu_src = 1'b1;
                            imm_src = imm_format(op_q);
                        end
                        ClsBeq: begin
                            pc_we  = alu_zero;
                            pc_src = 1'b1;
                        end
                        ClsJmp: begin
                            pc_we  = 1'b1;
                            pc_src = 1'b1;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    dmem_req = 1'b1;
                    mem_we   = (cls == ClsStore);
                end
                StWriteback: begin
                    reg_we     = 1'b1;
                    result_src = (cls == ClsLoad);
                end
                default: ;
            endcase
        end
    end

endmodule
